// File: rtl/traffic_demand_sensor.sv
// Demand-side front end for the traffic-light controller. It debounces the loop
// detectors, tracks a queue estimate for each approach, and times the green phase.
module traffic_demand_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_INTERVAL = 8,
  parameter int MIN_GREEN       = 16,
  parameter int MAX_GREEN       = 64,
  parameter int GAP_TIMEOUT     = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       det_NS,
  input  logic       det_EW,
  input  logic       green_NS,
  input  logic       green_EW,
  output logic [3:0] car_count_NS,
  output logic [3:0] car_count_EW,
  output logic       timer_done,
  output logic       overflow_NS,
  output logic       overflow_EW,
  output logic       conflict
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DP_W = (DEPART_INTERVAL > 1) ? $clog2(DEPART_INTERVAL) : 1;
  localparam logic [5:0] MIN_M1 = 6'(MIN_GREEN - 1);
  localparam logic [5:0] MAX_M1 = 6'(MAX_GREEN - 1);
  localparam logic [5:0] GAP_M1 = 6'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Lane 0 is the NS approach and lane 1 is the EW approach.
  logic [1:0] det;
  logic [1:0] green;
  logic [1:0] arrival;
  logic [1:0] tick;
  logic [1:0] overflow;
  logic [3:0] count [2];

  assign det   = {det_EW, det_NS};
  assign green = {green_EW, green_NS};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic            sync1_reg;
    logic            sync2_reg;
    logic            filt_reg;
    logic            filt_d_reg;
    logic [DB_W-1:0] stable_cnt_reg;
    logic [DP_W-1:0] depart_cnt_reg;
    logic [3:0]      count_reg;
    logic            overflow_reg;

    // The filtered level flips only after the synchronized input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_reg      <= 1'b0;
        sync2_reg      <= 1'b0;
        filt_reg       <= 1'b0;
        filt_d_reg     <= 1'b0;
        stable_cnt_reg <= '0;
      end else begin
        sync1_reg  <= det[gi];
        sync2_reg  <= sync1_reg;
        filt_d_reg <= filt_reg;
        if (sync2_reg == filt_reg) begin
          stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_reg       <= sync2_reg;
          stable_cnt_reg <= '0;
        end else begin
          stable_cnt_reg <= stable_cnt_reg + DB_W'(1);
        end
      end
    end

    assign arrival[gi] = filt_reg & ~filt_d_reg;
    assign tick[gi]    = green[gi] && (depart_cnt_reg == DP_W'(DEPART_INTERVAL - 1));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        depart_cnt_reg <= '0;
      end else if (!green[gi] || tick[gi]) begin
        depart_cnt_reg <= '0;
      end else begin
        depart_cnt_reg <= depart_cnt_reg + DP_W'(1);
      end
    end

    // When an arrival and a departure land in the same cycle, they cancel.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_reg    <= 4'd0;
        overflow_reg <= 1'b0;
      end else if (arrival[gi] && !tick[gi]) begin
        if (count_reg == 4'd15) begin
          overflow_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + 4'd1;
        end
      end else if (tick[gi] && !arrival[gi] && (count_reg != 4'd0)) begin
        count_reg <= count_reg - 4'd1;
      end
    end

    assign count[gi]    = count_reg;
    assign overflow[gi] = overflow_reg;
  end

  state_t     state_reg;
  state_t     state_next;
  logic [5:0] elapsed_reg;
  logic [5:0] elapsed_next;
  logic [5:0] gap_reg;
  logic [5:0] gap_next;
  logic       timer_done_reg;
  logic       timer_done_next;
  logic       conflict_reg;

  logic       any_green;
  logic [3:0] green_count;
  logic       green_arrival;
  logic       phase_end;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  // NS takes priority whenever both approaches claim green.
  assign any_green     = green_NS | green_EW;
  assign green_count   = green_NS ? count[0] : count[1];
  assign green_arrival = green_NS ? arrival[0] : arrival[1];
  assign phase_end     = (elapsed_reg == MAX_M1) ||
                         ((elapsed_reg >= MIN_M1) &&
                          ((gap_reg >= GAP_M1) || (green_count == 4'd0)));

  always_comb begin
    state_next      = state_reg;
    elapsed_next    = elapsed_reg;
    gap_next        = gap_reg;
    timer_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_green) begin
          state_next   = RUN;
          elapsed_next = 6'd0;
          gap_next     = 6'd0;
        end
      end
      RUN: begin
        if (!any_green) begin
          state_next = IDLE;
        end else if (phase_end) begin
          state_next      = DONE;
          timer_done_next = 1'b1;
        end else begin
          elapsed_next = sat_inc(elapsed_reg);
          gap_next     = green_arrival ? 6'd0 : sat_inc(gap_reg);
        end
      end
      DONE: begin
        if (!any_green) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      elapsed_reg    <= 6'd0;
      gap_reg        <= 6'd0;
      timer_done_reg <= 1'b0;
      conflict_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      elapsed_reg    <= elapsed_next;
      gap_reg        <= gap_next;
      timer_done_reg <= timer_done_next;
      conflict_reg   <= conflict_reg | (green_NS & green_EW);
    end
  end

  assign car_count_NS = count[0];
  assign car_count_EW = count[1];
  assign overflow_NS  = overflow[0];
  assign overflow_EW  = overflow[1];
  assign timer_done   = timer_done_reg;
  assign conflict     = conflict_reg;

endmodule

// File: doc/traffic_demand_sensor.md
Name: traffic_demand_sensor

Overview:
- Demand-side front end for the heuristic traffic-light controller.
- Converts raw NS/EW loop-detector inputs into debounced arrival events.
- Keeps saturating 4-bit queue counts per approach, draining them while that approach has green.
- Generates the one-cycle phase-end pulse (timer_done) from min-green, gap-out and max-green rules; consumes the controller's green_NS/green_EW.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before the filtered detector level changes
DEPART_INTERVAL, 8, green cycles per departing car (queue decrement period)
MIN_GREEN, 16, minimum RUN cycles before gap-out may end the phase
MAX_GREEN, 64, RUN cycles after which the phase ends unconditionally (MAX_GREEN > MIN_GREEN)
GAP_TIMEOUT, 12, RUN cycles without an arrival on the green approach that permit gap-out

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
det_NS  in  1  raw NS loop detector, asynchronous, high = vehicle present
det_EW  in  1  raw EW loop detector, asynchronous, high = vehicle present
green_NS  in  1  NS green from controller
green_EW  in  1  EW green from controller
car_count_NS  out  4  NS queue estimate, saturating 0..15
car_count_EW  out  4  EW queue estimate, saturating 0..15
timer_done  out  1  registered one-cycle phase-end pulse
overflow_NS  out  1  sticky: NS arrival occurred while count = 15
overflow_EW  out  1  sticky: EW arrival occurred while count = 15
conflict  out  1  sticky: green_NS and green_EW sampled high together

Behaviour:
- Reset values: all outputs 0; FSM IDLE; all counters 0; filtered detector levels 0; synchronizers 0.
- Detector path (per approach):
  - 2-flop synchronizer.
  - Debounce: filtered level takes the synchronized value once that value has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles. A single matching sample restarts the stability count.
  - Arrival event = one-cycle rising edge of the filtered level.
  - Raw-to-arrival latency: 2 + DEBOUNCE_CYCLES cycles.
- Departure tick (per approach):
  - Departure counter is held at 0 while that approach's green is low.
  - While green is high it counts 0..DEPART_INTERVAL-1. The tick fires on the cycle the counter equals DEPART_INTERVAL-1; the counter then wraps to 0.
- Queue count:
  - Arrival only: +1, saturating at 15; an arrival at 15 sets the sticky overflow flag.
  - Tick only: -1 if the count is greater than 0; a tick at 0 is ignored.
  - Arrival and tick in the same cycle: count unchanged, overflow not set.
- Phase-timer FSM: IDLE, RUN, DONE.
  - Effective green: green_NS if high, else green_EW. If both are high, NS is used and conflict is set (cleared only by reset).
  - IDLE: if either green is high, go to RUN; elapsed = 0, gap = 0.
  - RUN: elapsed +1 per cycle. gap resets to 0 on an arrival on the green approach, otherwise +1 (both 6-bit, saturating).
  - RUN end condition: elapsed == MAX_GREEN-1, OR (elapsed >= MIN_GREEN-1 AND (gap >= GAP_TIMEOUT-1 OR green approach count == 0)).
  - On that edge: state <= DONE, timer_done <= 1. timer_done clears on the following edge (exactly one cycle).
  - RUN with both greens low (controller reset/abort): go to IDLE, no pulse.
  - DONE: wait until both greens are low, then IDLE. timer_done is never reasserted in DONE.
- Arrivals on the non-green approach always count, in every state.
- Asynchronous reset mid-phase returns every output to its reset value immediately; operation resumes from IDLE.

Test Plan:
- Arrival debounce: det_NS high for 3 cycles, then low → count stays 0. det_NS high for 10 cycles → car_count_NS = 1, incremented 6 cycles after the rise.
- Saturation: 17 debounced EW pulses with both greens low → car_count_EW = 15, overflow_EW = 1 after the 16th pulse; the flag stays 1 until reset_n is asserted.
- Drain: car_count_NS = 3, green_NS held high → decrements at green cycles 8, 16 and 24, reaching 0.
- Gap-out: car_count_NS = 10, green_NS rises, no arrivals → timer_done pulses once, for 1 cycle, at RUN elapsed = 15 (MIN_GREEN bound dominates GAP_TIMEOUT).
- Max-out: green_EW high, EW arrival every 6 cycles, count kept at or above 5 → timer_done at elapsed = 63. Hold green_EW high 5 more cycles → no second pulse; green low → FSM IDLE.
- Abort and conflict:
  - Both greens high for 1 cycle → conflict = 1.
  - Green drops at elapsed = 5 → no timer_done; FSM IDLE.
  - reset_n low during RUN → all outputs 0 asynchronously.
